// File: rtl/clk_meas.sv
// clk_meas: measures the period and high time of a slow clock or strobe in
// clk_in cycles, with sticky stall detection and a lock flag that is set
// while consecutive captured periods match.
module clk_meas #(
  parameter int          WIDTH       = 32,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1000000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic             valid,
  output logic             timeout,
  output logic             locked
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  localparam logic [WIDTH-1:0] TO_W  = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   s, rise, fall;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       hcnt_q, hcnt_d;
  logic [WIDTH-1:0]       period_q, period_d;
  logic [WIDTH-1:0]       high_q, high_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;
  logic                   locked_q, locked_d;
  // Set once a period has been captured since the last ARM, so the first
  // capture never compares against a stale period from an earlier run.
  logic                   have_prev_q, have_prev_d;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  // Synchronizer chain on sig_in plus one delay flop for edge detection.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d_q  <= s;
    end
  end

  // State, counters and result registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      period_q    <= '0;
      high_q      <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      locked_q    <= 1'b0;
      have_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      locked_q    <= locked_d;
      have_prev_q <= have_prev_d;
    end
  end

  // Next-state logic: enable low dominates, a rise beats a same-cycle timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    period_d    = period_q;
    high_d      = high_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;
    locked_d    = locked_q;
    have_prev_d = have_prev_q;

    if (!enable) begin
      state_d     = IDLE;
      cnt_d       = '0;
      hcnt_d      = '0;
      locked_d    = 1'b0;
      have_prev_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = ARM;
          cnt_d       = '0;
          hcnt_d      = '0;
          have_prev_d = 1'b0;
        end
        ARM: begin
          if (rise) begin
            state_d = MEAS;
            cnt_d   = ONE_W;
            hcnt_d  = '0;
          end else if (cnt_q == TO_W) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + ONE_W;
          end
        end
        MEAS: begin
          if (rise) begin
            period_d    = cnt_q;
            high_d      = hcnt_q;
            valid_d     = 1'b1;
            timeout_d   = 1'b0;
            locked_d    = have_prev_q && (cnt_q == period_q);
            have_prev_d = 1'b1;
            cnt_d       = ONE_W;
            hcnt_d      = '0;
          end else if (cnt_q == TO_W) begin
            state_d     = ARM;
            timeout_d   = 1'b1;
            locked_d    = 1'b0;
            have_prev_d = 1'b0;
            cnt_d       = '0;
            hcnt_d      = '0;
          end else begin
            cnt_d = cnt_q + ONE_W;
            if (fall) hcnt_d = cnt_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign valid      = valid_q;
  assign timeout    = timeout_q;
  assign locked     = locked_q;

endmodule

// File: doc/clk_meas.md
Name: clk_meas

Overview:
- Measures a slow clock or periodic strobe (e.g. a divided clock) in units of the system clock `clk_in`.
- Synchronizes `sig_in` and detects its edges.
- Reports the period (rising edge to rising edge) and the high time.
- Flags a timeout when the signal stalls and a lock when consecutive periods match.
- Sits beside clock-divider outputs and external tick inputs, as the receiving/checking end of a generated clock.

Parameters:
- WIDTH, 32: width of the period/high counters and outputs.
- SYNC_STAGES, 2: number of synchronizer flops on `sig_in`; legal values 2..4.
- TIMEOUT, 1000000: `clk_in` cycles without a rising edge before timeout; 2 <= TIMEOUT <= 2^WIDTH-1.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  measurement enable; low forces IDLE.
- sig_in  input  1  asynchronous signal to measure.
- period_out  output  WIDTH  last measured period, in `clk_in` cycles.
- high_out  output  WIDTH  last measured high time, in `clk_in` cycles.
- valid  output  1  one-cycle pulse when `period_out`/`high_out` update.
- timeout  output  1  sticky stall flag.
- locked  output  1  high while the last two captured periods are equal.

Behaviour:
- Reset (async, active-high): FSM=IDLE; counters, `period_out`, `high_out`, `valid`, `timeout`, `locked` and all synchronizer/edge flops cleared to 0. Reset mid-measurement discards the partial count.
- Synchronizer: `sig_in` passes through SYNC_STAGES flops; the output `s` feeds one further flop `s_d`.
  - rise = `s` & ~`s_d`; fall = ~`s` & `s_d`.
  - Edge detection latency from `sig_in` transition: SYNC_STAGES cycles (+1 for metastability uncertainty).
- FSM states:
  - IDLE: counters held at 0, `valid`=0. `enable`=1 -> ARM.
  - ARM: waits for rise; falls ignored. On rise: cnt<=1, hcnt<=0 -> MEAS. `cnt` runs in ARM for timeout only.
  - MEAS: each cycle without rise, cnt<=cnt+1. On fall, hcnt<=cnt.
    - On rise: `period_out`<=cnt, `high_out`<=hcnt, `valid`<=1 for exactly one cycle, `timeout`<=0, cnt<=1, hcnt<=0; stay in MEAS.
- Count convention: rise detected at cycle t, next rise at t+P -> `period_out`=P. Fall at t+H -> `high_out`=H.
- Timeout:
  - Applies in ARM or MEAS when cnt reaches TIMEOUT with no rise.
  - Actions: `timeout`<=1 (sticky), `locked`<=0, `period_out`/`high_out` unchanged, no `valid`, cnt<=0, FSM -> ARM.
  - Covers `sig_in` stuck high or stuck low.
- Rise in the same cycle cnt==TIMEOUT: the rise wins (normal capture, no timeout).
- No fall between two rises (high pulse shorter than the sample period): `high_out`=0 is legal.
- `locked`: on each capture, `locked`<=(new period == previous captured period). The first capture after ARM has no previous period, so `locked`=0. Cleared on timeout and on leaving MEAS.
- `enable` low in any state: next cycle FSM=IDLE, cnt/hcnt cleared, `valid`=0, `locked`=0. `period_out`, `high_out` and `timeout` hold their values.
- Re-enable: restarts from ARM; the first `valid` appears a full period after the first rise.
- Arithmetic: unsigned WIDTH bits. cnt can never exceed TIMEOUT, so there is no wrap.

Test Plan:
- Reset: assert `rst` asynchronously mid-MEAS (between clock edges) -> all outputs 0 immediately; FSM in IDLE after release.
- 50% clock: `sig_in` toggles every 2 `clk_in` cycles (period 4), `enable`=1 -> first `valid` one period after the first detected rise with `period_out`=4, `high_out`=2; `locked`=1 from the second `valid` onward; `valid` pulses every 4 cycles.
- Asymmetric: `sig_in` high 3, low 7 cycles -> `period_out`=10, `high_out`=3, `locked`=1 on the second capture.
- Stall: TIMEOUT=50; `sig_in` stuck low after a lock -> `timeout`=1 and `locked`=0 50 cycles after the last rise; outputs keep 4/2. Resume toggling -> `timeout` clears on the next `valid`.
- Period change: switch period from 4 to 6 -> one capture of 6 with `locked`=0, then `locked`=1 on the next capture.
- Enable drop: deassert `enable` mid-period for 5 cycles, then reassert -> no `valid` while low; outputs held; first new `valid` one full period after the first rise following re-enable.
